barrel_sweep_ctrl: RTL and testbench



---
 rtl/barrel_sweep_ctrl_if.sv | 31 +++
 rtl/barrel_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_barrel_sweep_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer and its environment: start/operand
// controls, the shifter drive/return path, status flags and the buffer read port.
interface barrel_sweep_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] match_val;
  logic [WIDTH-1:0] sh_num;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] sh_result;
  logic             busy;
  logic             done;
  logic             found;
  logic [AMT_W-1:0] found_amt;
  logic [AMT_W-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;

  // Environment side: requests sweeps, closes the shifter loop, reads results.
  modport master (
    output start, din, match_val, sh_result, rd_addr,
    input  sh_num, sh_amt, busy, done, found, found_amt, rd_data
  );

  // Sequencer side.
  modport slave (
    input  start, din, match_val, sh_result, rd_addr,
    output sh_num, sh_amt, busy, done, found, found_amt, rd_data
  );
endinterface

// File: rtl/barrel_sweep_ctrl.sv
// Drives a combinational right barrel shifter through every shift amount,
// captures each result into a register buffer and records the first match.
module barrel_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  barrel_sweep_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << AMT_W;
  localparam logic [AMT_W-1:0] LAST_AMT = AMT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_match;
  logic [AMT_W-1:0] r_amt;
  logic             r_found;
  logic [AMT_W-1:0] r_found_amt;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_accept;
  logic             w_capture;
  logic             w_busy;
  logic             w_done;
  logic             w_last;
  logic             w_hit;
  logic [WIDTH-1:0] w_entry [DEPTH];

  assign w_last = (r_amt == LAST_AMT);
  assign w_hit  = !r_found && (bus.sh_result == r_match);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_SWEEP;
      S_SWEEP: if (w_last)    w_state_next = S_DONE;
      S_DONE:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs and datapath strobes.
  always_comb begin
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.start;
      end
      S_SWEEP: begin
        w_busy    = 1'b1;
        w_capture = 1'b1;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Operand/match registers and the amount counter; the counter parks at the
  // last amount after a sweep so sh_amt stays stable until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= '0;
      r_match     <= '0;
      r_amt       <= '0;
      r_found     <= 1'b0;
      r_found_amt <= '0;
    end else if (w_accept) begin
      r_num       <= bus.din;
      r_match     <= bus.match_val;
      r_amt       <= '0;
      r_found     <= 1'b0;
      r_found_amt <= '0;
    end else if (w_capture) begin
      if (w_hit) begin
        r_found     <= 1'b1;
        r_found_amt <= r_amt;
      end
      if (!w_last) begin
        r_amt <= r_amt + 1'b1;
      end
    end
  end

  // Result buffer: one register per amount so reset can clear every entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] r_data;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_capture && (r_amt == AMT_W'(gi))) begin
          r_data <= bus.sh_result;
        end
      end
      assign w_entry[gi] = r_data;
    end
  endgenerate

  // Registered read; a same-cycle write to the read index returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_entry[bus.rd_addr];
    end
  end

  assign bus.sh_num    = r_num;
  assign bus.sh_amt    = r_amt;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.found     = r_found;
  assign bus.found_amt = r_found_amt;
  assign bus.rd_data   = r_rd_data;

endmodule

// File: tb/tb_barrel_sweep_ctrl.sv
// Self-checking bench for barrel_sweep_ctrl with a logical right shifter model
// closing the loop and a reference model of the expected buffer and match.
module tb_barrel_sweep_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [7:0] ref_mem [8];
  logic       ref_found;
  logic [2:0] ref_found_amt;

  barrel_sweep_ctrl_if #(.WIDTH(8), .AMT_W(3)) bus ();

  barrel_sweep_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.sh_result = bus.sh_num >> bus.sh_amt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of a full sweep, straight from the shift definition.
  function automatic void model_sweep(input logic [7:0] d, input logic [7:0] m);
    int hits[$];
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = d >> i;
      if (ref_mem[i] == m) hits.push_back(i);
    end
    ref_found     = (hits.size() > 0);
    ref_found_amt = ref_found ? 3'(hits[0]) : 3'd0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    ref_found     = 1'b0;
    ref_found_amt = 3'd0;
  endfunction

  task automatic read_check(input logic [2:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.rd_addr = a;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== exp) begin
      errors++;
      $display("FAIL %s rd[%0d]: got %h expected %h", name, a, bus.rd_data, exp);
    end
  endtask

  task automatic readback_all(input string name);
    for (int i = 0; i < 8; i++) read_check(3'(i), ref_mem[i], name);
    $display("%s: readback of 8 entries checked", name);
  endtask

  task automatic check_flags(input logic [7:0] d, input string name);
    checks++;
    if (bus.found !== ref_found || bus.found_amt !== ref_found_amt) begin
      errors++;
      $display("FAIL %s found: got %b/%0d expected %b/%0d", name,
               bus.found, bus.found_amt, ref_found, ref_found_amt);
    end
    checks++;
    if (bus.sh_num !== d || bus.sh_amt !== 3'd7) begin
      errors++;
      $display("FAIL %s hold: sh_num=%h sh_amt=%0d expected %h/7", name, bus.sh_num, bus.sh_amt, d);
    end
  endtask

  // One sweep with cycle-level timing checks; intrude=1 pulses start with din=FF mid-sweep.
  task automatic do_sweep(input logic [7:0] d, input logic [7:0] m, input bit intrude, input string name);
    int busy_n;
    int done_n;
    int done_at;
    int amt_err;
    busy_n = 0; done_n = 0; done_at = -1; amt_err = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.din = d; bus.match_val = m;
    @(negedge clk);
    bus.start = 1'b0; bus.din = 8'($urandom); bus.match_val = 8'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k <= 8 && (bus.sh_amt !== 3'(k - 1) || bus.sh_num !== d)) amt_err++;
      if (intrude && k == 3) begin
        bus.start = 1'b1; bus.din = 8'hFF; bus.match_val = 8'hFF;
      end
      if (intrude && k == 4) bus.start = 1'b0;
      if (!bus.busy) break;
      @(negedge clk);
    end
    checks++;
    if (done_at != 9 || done_n != 1) begin
      errors++;
      $display("FAIL %s done: first at cycle %0d count %0d expected cycle 9 count 1", name, done_at, done_n);
    end
    checks++;
    if (busy_n != 9) begin
      errors++;
      $display("FAIL %s busy: high %0d cycles expected 9", name, busy_n);
    end
    checks++;
    if (amt_err != 0) begin
      errors++;
      $display("FAIL %s drive: %0d cycles with wrong sh_num/sh_amt expected 0", name, amt_err);
    end
    model_sweep(d, m);
    check_flags(d, name);
    $display("%s: din=%h match=%h found=%b amt=%0d done_at=%0d busy=%0d",
             name, d, m, bus.found, bus.found_amt, done_at, busy_n);
    readback_all(name);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.found !== 1'b0 || bus.found_amt !== 3'd0) begin
      errors++;
      $display("FAIL reset status: busy=%b done=%b found=%b amt=%0d expected all 0",
               bus.busy, bus.done, bus.found, bus.found_amt);
    end
    checks++;
    if (bus.sh_num !== 8'h00 || bus.sh_amt !== 3'd0 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset drive: sh_num=%h sh_amt=%0d rd_data=%h expected 0",
               bus.sh_num, bus.sh_amt, bus.rd_data);
    end
    $display("test_reset: status and drive checked");
    model_reset();
    readback_all("test_reset");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.din = 8'hD7; bus.match_val = 8'h1A;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.found !== 1'b0 || bus.sh_num !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid after edge: busy=%b found=%b sh_num=%h expected 0/0/00",
               bus.busy, bus.found, bus.sh_num);
    end
    for (int k = 0; k < 12; k++) begin
      if (bus.done || bus.busy) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_mid activity: %0d cycles with done/busy expected 0", done_seen);
    end
    $display("test_reset_mid: abort checked");
    model_reset();
    readback_all("test_reset_mid");
  endtask

  task automatic test_rst_and_start();
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.din = 8'hD7; bus.match_val = 8'hD7;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sh_num !== 8'h00) begin
      errors++;
      $display("FAIL rst_and_start: busy=%b sh_num=%h expected 0/00", bus.busy, bus.sh_num);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.found !== 1'b0) begin
      errors++;
      $display("FAIL rst_and_start later: busy=%b found=%b expected 0/0", bus.busy, bus.found);
    end
    $display("test_rst_and_start: reset priority checked");
    model_reset();
  endtask

  // Read of index 0 in the same cycle it is rewritten must return the prior sweep's value.
  task automatic test_read_during_write();
    logic [7:0] old0;
    old0 = ref_mem[0];
    @(negedge clk);
    bus.start = 1'b1; bus.din = 8'h5C; bus.match_val = 8'h17;
    @(negedge clk);
    bus.start = 1'b0; bus.rd_addr = 3'd0;
    @(negedge clk);
    checks++;
    if (bus.rd_data !== old0) begin
      errors++;
      $display("FAIL rdw old: got %h expected %h", bus.rd_data, old0);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 8'h5C) begin
      errors++;
      $display("FAIL rdw new: got %h expected 5c", bus.rd_data);
    end
    for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rdw timeout: busy=%b expected 0", bus.busy);
    end
    model_sweep(8'h5C, 8'h17);
    check_flags(8'h5C, "test_read_during_write");
    $display("test_read_during_write: old=%h new=5c", old0);
    readback_all("test_read_during_write");
  endtask

  // start held high: ignored during DONE, accepted once back in IDLE.
  task automatic test_back_to_back();
    int done_at[$];
    int idle_n;
    idle_n = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.din = 8'hB4; bus.match_val = 8'h2D;
    @(negedge clk);
    bus.din = 8'h9E; bus.match_val = 8'h13;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done) done_at.push_back(k);
      if (!bus.busy) idle_n++;
      if (k == 20) bus.start = 1'b0;
      else @(negedge clk);
    end
    checks++;
    if (done_at.size() != 2 || done_at[0] != 9 || done_at[1] != 19) begin
      errors++;
      $display("FAIL back_to_back done: %0d pulses first %0d expected 2 pulses at 9,19",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
    checks++;
    if (idle_n != 2) begin
      errors++;
      $display("FAIL back_to_back idle: %0d idle cycles expected 2", idle_n);
    end
    for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    model_sweep(8'h9E, 8'h13);
    check_flags(8'h9E, "test_back_to_back");
    $display("test_back_to_back: pulses=%0d idle=%0d", done_at.size(), idle_n);
    readback_all("test_back_to_back");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] m;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      if (n % 2 == 0) m = d >> $urandom_range(0, 7);
      else            m = 8'($urandom);
      do_sweep(d, m, 1'b0, "test_random");
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.din = 8'h00; bus.match_val = 8'h00; bus.rd_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    do_sweep(8'hD7, 8'h1A, 1'b0, "test_basic");
    do_sweep(8'hD7, 8'hFF, 1'b0, "test_no_match");
    do_sweep(8'h00, 8'h00, 1'b0, "test_first_match");
    do_sweep(8'hD7, 8'h1A, 1'b1, "test_start_while_busy");
    test_read_during_write();
    test_reset_mid();
    test_rst_and_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
